// File: rtl/read_bank_scheduler_if.sv
// Bus bundle between the read agents, the bank scheduler and the banked RAM.
// The scheduler uses the slave view; agents plus RAM together form the master view.
interface read_bank_scheduler_if #(
  parameter int NB_RDAGENT   = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4
);

  logic [NB_RDAGENT-1:0]              s_rdvalid;
  logic [NB_RDAGENT-1:0]              s_rdready;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   s_rdaddr;
  logic [NB_RDAGENT-1:0]              s_rddvalid;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   s_rddata;
  logic [NB_RDAGENT-1:0]              m_rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_addr;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   m_rddata;

  modport slave (
    input  s_rdvalid, s_rdaddr, m_rddata,
    output s_rdready, s_rddvalid, s_rddata, m_rden, m_addr, bank_select
  );

  modport master (
    output s_rdvalid, s_rdaddr, m_rddata,
    input  s_rdready, s_rddvalid, s_rddata, m_rden, m_addr, bank_select
  );

endinterface

// File: rtl/read_bank_scheduler.sv
// Per-cycle read scheduler in front of a banked RAM.
// Grants at most one agent per bank each cycle with a rotating priority pointer,
// registers the issued read enables/addresses/bank indices, and routes the RAM
// return data back to the issuing agent after RD_LATENCY cycles.
// Optional feature macro: READ_STALL_CNT_EN enables the saturating stall counter;
// without it stall_cnt is tied to zero.
module read_bank_scheduler #(
  parameter int NB_RDAGENT   = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int SELECT_RANGE = 3,
  parameter int RD_LATENCY   = 1
) (
  input  logic                 aclk,
  input  logic                 srst,
  read_bank_scheduler_if.slave bus,
  output logic [15:0]          stall_cnt
);

  localparam int PTR_W = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;

  logic [PTR_W-1:0]                   rr_ptr;
  logic [SELECT_RANGE-1:0]            bank [NB_RDAGENT];
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_sel_next;
  logic [NB_RDAGENT-1:0]              grant;
  logic [NB_RDAGENT-1:0]              transfer;
  logic                               collision;
  logic [NB_RDAGENT-1:0]              ret_pipe [RD_LATENCY];
  logic [NB_RDAGENT-1:0]              rddvalid;

  // Position of an agent in the current priority order; 0 is the agent at rr_ptr.
  function automatic int rank_of(input int idx, input int ptr);
    return (idx >= ptr) ? (idx - ptr) : (idx + NB_RDAGENT - ptr);
  endfunction

  // Extract each agent's bank index and its zero-extended bank_select field.
  always_comb begin
    bank_sel_next = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      bank[i] = bus.s_rdaddr[i*ADDR_WIDTH +: SELECT_RANGE];
      bank_sel_next[i*SELECT_WIDTH +: SELECT_WIDTH] = SELECT_WIDTH'(bank[i]);
    end
  end

  // A valid agent wins unless a higher-ranked valid agent targets the same bank.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (!srst && bus.s_rdvalid[i]) begin
        grant[i] = 1'b1;
        for (int j = 0; j < NB_RDAGENT; j++) begin
          if ((j != i) && bus.s_rdvalid[j] && (bank[j] == bank[i]) &&
              (rank_of(j, int'(rr_ptr)) < rank_of(i, int'(rr_ptr)))) begin
            grant[i] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.s_rdready = grant;
  assign transfer      = bus.s_rdvalid & grant;
  assign collision     = |(bus.s_rdvalid & ~grant);

  // Rotate priority after any cycle in which some valid agent was refused.
  always_ff @(posedge aclk) begin
    if (srst) begin
      rr_ptr <= '0;
    end else if (collision) begin
      rr_ptr <= (rr_ptr == PTR_W'(NB_RDAGENT - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  // Issue register toward the RAM banks; address and bank track the request bus every cycle.
  always_ff @(posedge aclk) begin
    if (srst) begin
      bus.m_rden      <= '0;
      bus.m_addr      <= '0;
      bus.bank_select <= '0;
    end else begin
      bus.m_rden      <= transfer;
      bus.m_addr      <= bus.s_rdaddr;
      bus.bank_select <= bank_sel_next;
    end
  end

  // Return pipe tracking which agents have a read in flight at each latency stage.
  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        ret_pipe[k] <= '0;
      end
    end else begin
      ret_pipe[0] <= bus.m_rden;
      for (int k = 1; k < RD_LATENCY; k++) begin
        ret_pipe[k] <= ret_pipe[k-1];
      end
    end
  end

  assign rddvalid       = ret_pipe[RD_LATENCY-1];
  assign bus.s_rddvalid = rddvalid;

  // Pass RAM data straight to its agent, zeroed when no return is due.
  always_comb begin
    bus.s_rddata = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (rddvalid[i]) begin
        bus.s_rddata[i*DATA_WIDTH +: DATA_WIDTH] = bus.m_rddata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef READ_STALL_CNT_EN
  // Count collision cycles, sticking at the maximum value.
  always_ff @(posedge aclk) begin
    if (srst) begin
      stall_cnt <= 16'h0000;
    end else if (collision && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_read_bank_scheduler.sv
// Self-checking bench for read_bank_scheduler (3 agents, 3-cycle RAM latency).
// Directed scenarios plus randomized traffic, all compared against a
// transaction-level reference model kept in this file.
module tb_read_bank_scheduler;

  localparam int NB  = 3;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int SR  = 3;
  localparam int LAT = 3;
`ifdef READ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        srst = 1'b1;
  logic [15:0] stall_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  read_bank_scheduler_if #(.NB_RDAGENT(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) bus ();

  read_bank_scheduler #(
    .NB_RDAGENT(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SELECT_WIDTH(SW), .SELECT_RANGE(SR), .RD_LATENCY(LAT)
  ) dut (
    .aclk      (aclk),
    .srst      (srst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 aclk = ~aclk;

  // Reference model state: priority pointer, stall count, and issue history by age
  int             rr_m;
  int             stall_m;
  logic [NB-1:0]  hist [1:LAT+1];
  logic [NB*AW-1:0] exp_addr;
  logic [NB*SW-1:0] exp_bsel;
  logic [NB-1:0]  g_exp;
  logic [NB-1:0]  last_ready;

  // Walk agents in priority order; the first one to claim a bank gets it.
  function automatic logic [NB-1:0] modelGrants(input logic [NB-1:0] v, input logic [NB*AW-1:0] a,
                                                input int rr, input logic rst);
    logic [NB-1:0] g;
    bit taken [1<<SR];
    g = '0;
    for (int b = 0; b < (1<<SR); b++) taken[b] = 1'b0;
    if (rst) return '0;
    for (int k = 0; k < NB; k++) begin
      int ag;
      int bk;
      ag = (rr + k) % NB;
      bk = int'(a[ag*AW +: SR]);
      if (v[ag] && !taken[bk]) begin
        g[ag] = 1'b1;
        taken[bk] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] v, input logic [NB*AW-1:0] a, input logic rst);
    srst          = rst;
    bus.s_rdvalid = v;
    bus.s_rdaddr  = a;
    for (int i = 0; i < NB; i++) bus.m_rddata[i*DW +: DW] = $urandom;
  endtask

  task automatic checkOutput();
    checkValue("s_rdready", 64'(last_ready), 64'(g_exp));
    checkValue("m_rden", 64'(bus.m_rden), 64'(hist[1]));
    checkValue("s_rddvalid", 64'(bus.s_rddvalid), 64'(hist[LAT+1]));
    checkValue("m_addr", 64'(bus.m_addr), 64'(exp_addr));
    checkValue("bank_select", 64'(bus.bank_select), 64'(exp_bsel));
    checkValue("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    for (int i = 0; i < NB; i++) begin
      checkValue("s_rddata", 64'(bus.s_rddata[i*DW +: DW]),
                 hist[LAT+1][i] ? 64'(bus.m_rddata[i*DW +: DW]) : 64'd0);
    end
  endtask

  // One clock: sample/compare at the falling edge, then advance the model at the rising edge.
  task automatic step(input bit chk);
    logic [NB-1:0] coll;
    @(negedge aclk);
    g_exp      = modelGrants(bus.s_rdvalid, bus.s_rdaddr, rr_m, srst);
    last_ready = bus.s_rdready;
    if (chk) checkOutput();
    @(posedge aclk);
    if (srst) begin
      rr_m = 0;
      stall_m = 0;
      for (int k = 1; k <= LAT+1; k++) hist[k] = '0;
      exp_addr = '0;
      exp_bsel = '0;
    end else begin
      coll = bus.s_rdvalid & ~g_exp;
      for (int k = LAT+1; k > 1; k--) hist[k] = hist[k-1];
      hist[1]  = g_exp;
      exp_addr = bus.s_rdaddr;
      for (int i = 0; i < NB; i++) exp_bsel[i*SW +: SW] = SW'(bus.s_rdaddr[i*AW +: SR]);
      if (coll != '0) begin
        rr_m = (rr_m + 1) % NB;
        if (STALL_EN && stall_m < 65535) stall_m++;
      end
    end
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, random traffic and counter saturation, in order.
  initial begin
    logic [NB-1:0]    rv;
    logic [NB*AW-1:0] ra;
    int               n_sat;

    rr_m = 0;
    stall_m = 0;
    for (int k = 1; k <= LAT+1; k++) hist[k] = '0;
    exp_addr = '0;
    exp_bsel = '0;
    bus.s_rdvalid = '0;
    bus.s_rdaddr  = '0;
    bus.m_rddata  = '0;

    // Reset held with every agent requesting
    applyStimulus(3'b111, {8'h02, 8'h01, 8'h00}, 1'b1);
    step(1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b111, {8'h02, 8'h01, 8'h00}, 1'b1);
      step(1'b1);
      checkValue("rst_ready", 64'(last_ready), 64'd0);
      checkValue("rst_rden", 64'(bus.m_rden), 64'd0);
      checkValue("rst_dvalid", 64'(bus.s_rddvalid), 64'd0);
      checkValue("rst_rddata", 64'(|bus.s_rddata), 64'd0);
      checkValue("rst_stall", 64'(stall_cnt), 64'd0);
    end

    // Release: distinct banks 0/1/2 every cycle
    applyStimulus(3'b111, {8'h02, 8'h01, 8'h00}, 1'b0);
    step(1'b1);
    checkValue("first_grant", 64'(last_ready), 64'h7);
    checkValue("first_rden", 64'(bus.m_rden), 64'h7);
    checkValue("first_bsel", 64'(bus.bank_select), 64'h210);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b111, {8'h02, 8'h01, 8'h00}, 1'b0);
      step(1'b1);
      checkValue("distinct_ready", 64'(last_ready), 64'h7);
      checkValue("distinct_rden", 64'(bus.m_rden), 64'h7);
      checkValue("distinct_dvalid", 64'(bus.s_rddvalid), (c == 2) ? 64'h7 : 64'h0);
      checkValue("distinct_stall", 64'(stall_cnt), 64'd0);
    end

    // Same-bank collision between agents 0 and 1
    applyStimulus(3'b011, {8'h00, 8'h10, 8'h08}, 1'b0);
    step(1'b1);
    checkValue("coll_first", 64'(last_ready), 64'h1);
    applyStimulus(3'b010, {8'h00, 8'h10, 8'h08}, 1'b0);
    step(1'b1);
    checkValue("coll_second", 64'(last_ready), 64'h2);
    checkValue("coll_stall", 64'(stall_cnt), STALL_EN ? 64'd1 : 64'd0);
    applyStimulus(3'b011, {8'h00, 8'h10, 8'h08}, 1'b0);
    step(1'b1);
    checkValue("coll_rr_moved", 64'(last_ready), 64'h2);

    // Fairness: everyone hammers bank 5 from a fresh reset
    applyStimulus(3'b000, '0, 1'b1);
    step(1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b111, {8'h15, 8'h0D, 8'h05}, 1'b0);
      step(1'b1);
      checkValue("fair_grant", 64'(last_ready), 64'(3'b001 << (k % 3)));
      checkValue("fair_stall", 64'(stall_cnt), STALL_EN ? 64'(k + 1) : 64'd0);
    end

    // Return routing to agent 1
    applyStimulus(3'b000, '0, 1'b1);
    step(1'b1);
    applyStimulus(3'b010, {8'h00, 8'h22, 8'h00}, 1'b0);
    bus.m_rddata[DW +: DW] = 32'hDEADBEEF;
    step(1'b1);
    checkValue("route_rden", 64'(bus.m_rden), 64'h2);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b000, {8'h00, 8'h22, 8'h00}, 1'b0);
      bus.m_rddata[DW +: DW] = 32'hDEADBEEF;
      step(1'b1);
      checkValue("route_dvalid", 64'(bus.s_rddvalid[1]), (c == 2) ? 64'd1 : 64'd0);
      if (c == 2) checkValue("route_data", 64'(bus.s_rddata[DW +: DW]), 64'hDEADBEEF);
    end

    // Second read killed by reset while in flight
    applyStimulus(3'b010, {8'h00, 8'h33, 8'h00}, 1'b0);
    step(1'b1);
    applyStimulus(3'b000, {8'h00, 8'h33, 8'h00}, 1'b0);
    step(1'b1);
    applyStimulus(3'b000, {8'h00, 8'h33, 8'h00}, 1'b1);
    step(1'b1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b000, {8'h00, 8'h33, 8'h00}, 1'b0);
      bus.m_rddata[DW +: DW] = 32'hDEADBEEF;
      step(1'b1);
      checkValue("flush_dvalid", 64'(bus.s_rddvalid), 64'd0);
    end

    // Randomized traffic with a crowded bank space and occasional reset
    for (int c = 0; c < 400; c++) begin
      rv = NB'($urandom);
      for (int i = 0; i < NB; i++) ra[i*AW +: AW] = {5'($urandom), 3'($urandom_range(0, 2))};
      applyStimulus(rv, ra, ($urandom_range(0, 39) == 0));
      step(1'b1);
    end

    // Long collision run for counter saturation (or a zero counter when disabled)
    applyStimulus(3'b000, '0, 1'b1);
    step(1'b1);
    n_sat = STALL_EN ? 70000 : 2000;
    applyStimulus(3'b111, {8'h14, 8'h0C, 8'h04}, 1'b0);
    for (int c = 0; c < n_sat; c++) step(c % 500 == 0);
    step(1'b1);
    checkValue("stall_final", 64'(stall_cnt), STALL_EN ? 64'hFFFF : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
